// File: rtl/rv16_wb_scheduler.sv
// rtl/rv16_wb_scheduler.sv - rv16 write-back arbiter, write-back stage and hazard scoreboard
// Round-robin ALU/load arbitration feeding one registered write-back stage; busy bits gate issue.
module rv16_wb_scheduler #(
  parameter int DATA   = 16,
  parameter int OPCODE = 4
) (
  input  logic                     rv16_wb_clock,
  input  logic                     rv16_wb_reset,
  input  logic                     issue_valid_in,
  input  logic                     issue_writes_in,
  input  logic [OPCODE-1:0]        issue_rd_addr_in,
  input  logic [OPCODE-1:0]        issue_rs1_addr_in,
  input  logic [OPCODE-1:0]        issue_rs2_addr_in,
  output logic                     issue_stall_out,
  input  logic                     alu_valid_in,
  input  logic [OPCODE-1:0]        alu_rd_addr_in,
  input  logic [DATA-1:0]          alu_data_in,
  output logic                     alu_ready_out,
  input  logic                     mem_valid_in,
  input  logic [OPCODE-1:0]        mem_rd_addr_in,
  input  logic [DATA-1:0]          mem_data_in,
  output logic                     mem_ready_out,
  output logic [OPCODE-1:0]        rd_addr_out,
  output logic [DATA-1:0]          rd_reg_out,
  output logic [(1<<OPCODE)-1:0]   busy_out,
  output logic [15:0]              stall_count_out
);

  localparam int NREG = 1 << OPCODE;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              ptr_q, ptr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [OPCODE-1:0] wb_addr_q, wb_addr_d;
  logic [DATA-1:0]   wb_data_q, wb_data_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              alu_grant, mem_grant;
  logic              stall, issue_accept;
  logic [NREG-1:0]   busy_set, busy_clr;
  logic [OPCODE-1:0] grant_addr;
  logic [DATA-1:0]   grant_data;

  // ptr_q = 1 means the ALU won the last grant, so the load unit wins the next tie.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!rv16_wb_reset) begin
      if (alu_valid_in && (!mem_valid_in || !ptr_q)) begin
        alu_grant = 1'b1;
      end else if (mem_valid_in) begin
        mem_grant = 1'b1;
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!rv16_wb_reset && issue_valid_in) begin
      stall = busy_q[issue_rs1_addr_in] | busy_q[issue_rs2_addr_in] |
              (issue_writes_in & busy_q[issue_rd_addr_in]);
    end
    issue_accept = !rv16_wb_reset && issue_valid_in && !stall && issue_writes_in;
  end

  always_comb begin
    grant_addr = alu_grant ? alu_rd_addr_in : mem_rd_addr_in;
    grant_data = alu_grant ? alu_data_in : mem_data_in;
    ptr_d      = alu_grant ? 1'b1 : (mem_grant ? 1'b0 : ptr_q);
    // Register 0 and idle cycles both present addr 0 / data 0 so register-file bypass of r0 reads 0.
    if ((alu_grant || mem_grant) && grant_addr != '0) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = grant_addr;
      wb_data_d  = grant_data;
    end else begin
      wb_valid_d = 1'b0;
      wb_addr_d  = '0;
      wb_data_d  = '0;
    end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_accept && issue_rd_addr_in != '0) begin
      busy_set = NREG'(1) << issue_rd_addr_in;
    end
    if (wb_valid_q) begin
      busy_clr = NREG'(1) << wb_addr_q;
    end
    busy_d = ((busy_q & ~busy_clr) | busy_set) & ~NREG'(1);
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge rv16_wb_clock) begin
    if (rv16_wb_reset) begin
      busy_q      <= '0;
      ptr_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_stall_out = stall;
  assign alu_ready_out   = alu_grant;
  assign mem_ready_out   = mem_grant;
  assign rd_addr_out     = wb_addr_q;
  assign rd_reg_out      = wb_data_q;
  assign busy_out        = busy_q;
  assign stall_count_out = stall_cnt_q;

endmodule

// File: doc/rv16_wb_scheduler.md
# rv16_wb_scheduler

Write-back scheduler and hazard scoreboard for the rv16 16x16 register file. It arbitrates the file's single write port between the ALU and the load unit, drives the file's `rd_addr_in`/`rd_reg_in` from one registered write-back stage, and tracks registers with an outstanding write. Issue logic uses that tracking to stall on RAW and WAW hazards. The block sits between the execute/memory units and the register file.

## Interface
- `DATA`, 16: data width.
- `OPCODE`, 4: register address width; the block tracks 2**OPCODE registers.
- `rv16_wb_clock`  in  1  clock; all state updates on the rising edge.
- `rv16_wb_reset`  in  1  synchronous, active-high reset.
- `issue_valid_in`  in  1  decode presents an instruction this cycle.
- `issue_writes_in`  in  1  the presented instruction writes `rd`.
- `issue_rd_addr_in`  in  OPCODE  destination register of the presented instruction.
- `issue_rs1_addr_in`  in  OPCODE  first source register.
- `issue_rs2_addr_in`  in  OPCODE  second source register.
- `issue_stall_out`  out  1  the instruction must not issue this cycle.
- `alu_valid_in`  in  1  ALU write-back request.
- `alu_rd_addr_in`  in  OPCODE  ALU write-back destination.
- `alu_data_in`  in  DATA  ALU write-back data.
- `alu_ready_out`  out  1  ALU request granted this cycle.
- `mem_valid_in`  in  1  load-unit write-back request.
- `mem_rd_addr_in`  in  OPCODE  load-unit write-back destination.
- `mem_data_in`  in  DATA  load-unit write-back data.
- `mem_ready_out`  out  1  load-unit request granted this cycle.
- `rd_addr_out`  out  OPCODE  to the register file `rd_addr_in`.
- `rd_reg_out`  out  DATA  to the register file `rd_reg_in`.
- `busy_out`  out  2**OPCODE  scoreboard; bit n set means register n has a pending write.
- `stall_count_out`  out  16  count of stalled issue cycles, saturating.

## Operation
- **Scoreboard set.** A bit is set when an issue is accepted, meaning all of these hold: `issue_valid_in`, no `issue_stall_out`, `issue_writes_in`, and `issue_rd_addr_in != 0`.
- **Scoreboard clear.** A bit is cleared on the edge where the write-back stage holds a valid write to that address.
- **Set/clear collision.** If a set and a clear hit the same bit in one cycle, set wins. The stall rule makes this unreachable; implement it anyway.
- **Register 0.** Register 0 is never marked busy.
- **Stall rule.** `issue_stall_out = issue_valid_in & (busy[rs1] | busy[rs2] | (issue_writes_in & busy[rd]))`.
  - The rule uses registered busy bits only. A clear occurring in the same cycle does not release the stall.
  - The `rs2` term applies even when the instruction does not use `rs2`. This is a conservative stall.
- **Arbitration.** Round-robin between the two requesters, tracked by a 1-bit last-grant pointer.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last time wins.
  - After reset the pointer is "mem", so the ALU wins the first tie.
  - `*_ready_out` is combinational from the valids and the pointer. At most one ready is high per cycle.
- **Handshake.** A transfer occurs when valid and ready are both high.
  - A requester holds valid, address and data stable until it sees ready.
  - The write-back stage drains every cycle, so one grant is possible every cycle.
- **Write-back stage.** A granted request loads `{addr, data, valid}` into the stage register.
- **Idle.** With no grant, the stage loads addr 0 and data 0. This matters because the register file bypasses `rd_reg_in` to a read port whenever its read address equals `rd_addr_in`, so reads of register 0 must still see 0.
- **Write-back to register 0.** Such a request is accepted and consumes a grant slot. The stage drives addr 0 and data 0, and there is no scoreboard effect.
- **Stall counter.** `stall_count_out` increments on each cycle with `issue_stall_out` high and saturates at 0xFFFF.

## Timing
- **Reset values.** In a reset cycle, the following all load 0 at the edge:
  - `rd_addr_out`, `rd_reg_out` and the stage valid;
  - `busy_out`;
  - `stall_count_out`;
  - the pointer, which loads "mem".
- **Outputs held at 0 during reset.** While reset is high, `alu_ready_out`, `mem_ready_out` and `issue_stall_out` are forced to 0. Requests present in a reset cycle are not accepted.
- **Reset mid-operation.** Any write held in the stage is dropped and never reaches the register file. All busy bits clear.
- **Grant-to-write latency.** A grant in cycle N appears on `rd_addr_out`/`rd_reg_out` in cycle N+1. The register file writes it at the end of N+1.
- **Busy-clear latency.** The busy bit falls in cycle N+2. A dependent instruction therefore issues in N+2 at the earliest.
- **Issue-to-busy latency.** An issue accepted in cycle M shows its busy bit from cycle M+1.
- **Combinational paths.** `issue_stall_out` and the ready outputs are combinational in the current cycle. All other outputs are registered.

## Test plan
- **Reset.** Hold reset with both valids high → readies 0, all outputs 0. In the first cycle after reset, with both valid → `alu_ready_out`=1.
- **RAW hazard.** Issue rd=3 in cycle 0 → `busy_out`=0x0008 in cycle 1. An issue with rs1=3 stalls. ALU granted (rd=3, 0xBEEF) in cycle 2 → `rd_addr_out`=3, `rd_reg_out`=0xBEEF in cycle 3, busy 0 and stall released in cycle 4.
- **Round-robin.** Both valid for 4 cycles with mem addr 5/0x1111 and ALU addr 6/0x2222 → grants ALU, mem, ALU, mem. Outputs alternate one cycle later.
- **Register 0.** Issue with rd=0 → `busy_out` stays 0. Write-back to 0 with data 0xFFFF → `rd_reg_out`=0.
- **Mid-operation reset.** Grant with rd=7 and busy[7] set, then assert reset the next cycle → `rd_addr_out`=0, busy 0.
- **Counter saturation.** Hold a stall for 70000 cycles → `stall_count_out`=0xFFFF and stays there.
